arb_rr_n: RTL

- Parametrised N-requester arbiter; successor to the two-requester fixed-priority grant FSM.
- Adds a selectable policy (fixed priority or round-robin), an owner hold/park rule, and an optional maximum-hold timeout that forces rotation.
- Outputs are registered: one-hot grant, grant-valid and encoded owner ID.
- Sits between N bus masters and a shared resource.

---
 rtl/arb_rr_n_if.sv | 39 +++
 rtl/arb_rr_n.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/arb_rr_n_if.sv
// Request/grant bundle between N bus masters and the arbiter.
// Latency: none (wires only).
// Backpressure: none; req is level-held by each master until it is served or dropped.
//
// Ports (signals):
//   req       N    request vector, bit i = requester i (master -> arbiter)
//   gnt       N    one-hot grant (arbiter -> master)
//   gnt_valid 1    any grant bit set
//   gnt_id    IDW  encoded owner index, meaningful only while gnt_valid = 1
//   timeout   1    one-cycle pulse on the first cycle of a forced-rotation grant
interface arb_rr_n_if #(
  parameter int N = 4
) ();
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IDW-1:0] gnt_id;
  logic           timeout;

  // Requester side.
  modport master (
    output req,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  timeout
  );

  // Arbiter side.
  modport slave (
    input  req,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output timeout
  );
endinterface

// File: rtl/arb_rr_n.sv
// N-requester arbiter with fixed-priority or round-robin policy, owner hold and max-hold timeout.
// Latency: req sampled at a clk edge is reflected in the registered grant outputs right after that edge.
// Backpressure: an owner keeps the grant while it holds req, unless MAX_HOLD forces rotation to a waiter.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - arb_rr_n_if slave modport: req in; gnt, gnt_valid, gnt_id, timeout out (all registered)
module arb_rr_n #(
  parameter int N        = 4,
  parameter int RR_MODE  = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  arb_rr_n_if.slave  bus
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  // Highest value the hold counter may reach; with the timeout disabled it stays at 0.
  localparam logic [7:0] HOLD_LIM = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           timeout_q, timeout_d;
  logic [7:0]     hold_cnt_q, hold_cnt_d;
  logic [IDW-1:0] last_q, last_d;

  logic [N-1:0]   cand;
  logic           do_arb;
  logic           forced;
  logic           own_req;
  logic           others_req;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  int             start_i;
  int             pos;

  // gnt_q is the one-hot owner mask while BUSY, so it doubles as the owner select.
  assign own_req    = |(bus.req & gnt_q);
  assign others_req = |(bus.req & ~gnt_q);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    timeout_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    last_d      = last_q;
    cand        = '0;
    do_arb      = 1'b0;
    forced      = 1'b0;
    win_found   = 1'b0;
    win_idx     = '0;
    start_i     = 0;
    pos         = 0;

    // Decide whether to arbitrate this cycle and over which candidates.
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          cand   = bus.req;
          do_arb = 1'b1;
        end
      end
      BUSY: begin
        if (own_req) begin
          if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM) && others_req) begin
            // Owner has used its full allowance while someone waits: exclude it.
            cand   = bus.req & ~gnt_q;
            do_arb = 1'b1;
            forced = 1'b1;
          end else if (hold_cnt_q < HOLD_LIM) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end else begin
          // Owner dropped; its req bit is already 0 so it cannot win again here.
          cand   = bus.req;
          do_arb = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    // Circular search. Fixed mode always starts at index 0; round-robin
    // starts just past the last owner. last_q = N-1 wraps the start to 0.
    start_i = (RR_MODE != 0) ? (int'(last_q) + 1) : 0;
    for (int k = 0; k < N; k++) begin
      pos = start_i + k;
      if (pos >= N) begin
        pos = pos - N;
      end
      if (!win_found && cand[IDW'(pos)]) begin
        win_found = 1'b1;
        win_idx   = IDW'(pos);
      end
    end

    if (do_arb) begin
      if (win_found) begin
        state_d       = BUSY;
        gnt_d         = '0;
        gnt_d[win_idx] = 1'b1;
        gnt_id_d      = win_idx;
        hold_cnt_d    = 8'd0;
        timeout_d     = forced;
        if (RR_MODE != 0) begin
          last_d = win_idx;
        end
      end else begin
        state_d    = IDLE;
        gnt_d      = '0;
        gnt_id_d   = '0;
        hold_cnt_d = 8'd0;
      end
    end

    gnt_valid_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= 8'd0;
      last_q      <= IDW'(N - 1);
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
      last_q      <= last_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.timeout   = timeout_q;

endmodule
